// File: rtl/phy_mdio_ctrl.sv
// Autonomous MDIO manager for the LAN8720: ID check, BMCR setup and periodic BMSR
// link polling. The MDIO pad is built at top level from mdio_o/mdio_oe/mdio_i.
module phy_mdio_ctrl #(
  parameter int          CLK_DIV        = 14,
  parameter logic [4:0]  PHY_ADDR       = 5'd1,
  parameter logic [15:0] BMCR_VALUE     = 16'h3300,
  parameter int          STARTUP_CYCLES = 270000,
  parameter int          POLL_CYCLES    = 2700000,
  parameter logic [15:0] ID1_EXPECT     = 16'h0007,
  parameter logic [11:0] ID2_EXPECT     = 12'hC0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdio_i,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        busy,
  output logic        phy_ready,
  output logic        link_up,
  output logic        link_change,
  output logic        err,
  output logic [31:0] phy_id
);

  typedef enum logic [2:0] {
    WAIT_START, RD_ID1, RD_ID2, CHECK_ID, WR_BMCR, POLL_WAIT, RD_BMSR, FAULT
  } state_t;

  state_t      state, state_next;
  logic        start;
  logic        start_wr;
  logic [4:0]  start_reg;
  logic [63:0] start_frame;
  logic [31:0] wait_cnt;
  logic [31:0] wait_limit;
  logic        wait_done;
  logic [15:0] div_cnt;
  logic        div_end;
  logic [5:0]  bit_cnt;
  logic        frame_wr;
  logic [63:0] shift_out;
  logic [15:0] shift_in;
  logic        done;

  // Full 64-bit frame as driven; TA/data of a read are placeholders never driven.
  function automatic logic [63:0] frame_bits(input logic wr, input logic [4:0] reg_addr);
    frame_bits = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), PHY_ADDR, reg_addr,
                  (wr ? 2'b10 : 2'b11), (wr ? BMCR_VALUE : 16'hFFFF)};
  endfunction

  assign div_end     = (div_cnt == 16'(CLK_DIV - 1));
  assign start_frame = frame_bits(start_wr, start_reg);

  // Wait-counter terminal value for the current idle state.
  always_comb begin
    wait_limit = 32'(POLL_CYCLES - 1);
    if (state == WAIT_START) begin
      wait_limit = 32'(STARTUP_CYCLES - 1);
    end else begin
      wait_limit = 32'(POLL_CYCLES - 1);
    end
    wait_done = (wait_cnt == wait_limit);
  end

  // Next-state logic; a frame is launched on the same cycle its state is entered.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_wr   = 1'b0;
    start_reg  = 5'd0;
    case (state)
      WAIT_START: if (wait_done) begin
        state_next = RD_ID1;
        start      = 1'b1;
        start_reg  = 5'd2;
      end else begin
        state_next = WAIT_START;
      end
      RD_ID1: if (done) begin
        state_next = RD_ID2;
        start      = 1'b1;
        start_reg  = 5'd3;
      end else begin
        state_next = RD_ID1;
      end
      RD_ID2: if (done) begin
        state_next = CHECK_ID;
      end else begin
        state_next = RD_ID2;
      end
      CHECK_ID: if ((phy_id[31:16] == ID1_EXPECT) && (phy_id[15:4] == ID2_EXPECT)) begin
        state_next = WR_BMCR;
        start      = 1'b1;
        start_wr   = 1'b1;
        start_reg  = 5'd0;
      end else begin
        state_next = FAULT;
      end
      WR_BMCR: if (done) begin
        state_next = POLL_WAIT;
      end else begin
        state_next = WR_BMCR;
      end
      POLL_WAIT: if (wait_done) begin
        state_next = RD_BMSR;
        start      = 1'b1;
        start_reg  = 5'd1;
      end else begin
        state_next = POLL_WAIT;
      end
      RD_BMSR: if (done) begin
        state_next = POLL_WAIT;
      end else begin
        state_next = RD_BMSR;
      end
      FAULT:   state_next = FAULT;
      default: state_next = WAIT_START;
    endcase
  end

  // Frame engine: MDC generation, MSB-first shift out, read data capture on MDC rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      div_cnt   <= 16'd0;
      bit_cnt   <= 6'd0;
      frame_wr  <= 1'b0;
      shift_out <= 64'hFFFF_FFFF_FFFF_FFFF;
      shift_in  <= 16'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy      <= 1'b1;
        mdc       <= 1'b0;
        div_cnt   <= 16'd0;
        bit_cnt   <= 6'd0;
        frame_wr  <= start_wr;
        shift_out <= start_frame;
        mdio_o    <= start_frame[63];
        mdio_oe   <= 1'b1;
      end else if (busy) begin
        if (!div_end) begin
          div_cnt <= div_cnt + 16'd1;
        end else begin
          div_cnt <= 16'd0;
          if (!mdc) begin
            mdc <= 1'b1;
            if (bit_cnt >= 6'd48) begin
              shift_in <= {shift_in[14:0], mdio_i};
            end
          end else if (bit_cnt == 6'd63) begin
            mdc     <= 1'b0;
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            mdc       <= 1'b0;
            bit_cnt   <= bit_cnt + 6'd1;
            mdio_o    <= shift_out[62];
            shift_out <= {shift_out[62:0], 1'b1};
            // Reads release the line from the TA field (bit 46) onward.
            mdio_oe   <= frame_wr | (bit_cnt < 6'd45);
          end
        end
      end
    end
  end

  // Sequencer state, idle counters and exported status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_START;
      wait_cnt    <= 32'd0;
      phy_ready   <= 1'b0;
      link_up     <= 1'b0;
      link_change <= 1'b0;
      err         <= 1'b0;
      phy_id      <= 32'd0;
    end else begin
      state       <= state_next;
      link_change <= 1'b0;
      if (((state == WAIT_START) || (state == POLL_WAIT)) && !wait_done) begin
        wait_cnt <= wait_cnt + 32'd1;
      end else begin
        wait_cnt <= 32'd0;
      end
      if ((state == RD_ID1) && done) begin
        phy_id[31:16] <= shift_in;
      end else if ((state == RD_ID2) && done) begin
        phy_id[15:0] <= shift_in;
      end else if ((state == WR_BMCR) && done) begin
        phy_ready <= 1'b1;
      end else if ((state == RD_BMSR) && done) begin
        link_up     <= shift_in[2];
        link_change <= shift_in[2] ^ link_up;
      end else if ((state == CHECK_ID) && (state_next == FAULT)) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

endmodule

// File: tb/tb_phy_mdio_ctrl.sv
// Scoreboard bench for phy_mdio_ctrl: a PHY model answers reads, a monitor decodes
// every frame and compares it with the expected-frame queue filled by the stimulus.
module tb_phy_mdio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdio_i;
  logic        mdc, mdio_o, mdio_oe, busy, phy_ready, link_up, link_change, err;
  logic [31:0] phy_id;
  logic        phy_oe = 1'b0;
  logic        phy_o  = 1'b1;

  // Pulled-up shared line: controller wins when driving, else the PHY model.
  assign mdio_i = mdio_oe ? mdio_o : (phy_oe ? phy_o : 1'b1);

  phy_mdio_ctrl #(
    .CLK_DIV(2), .PHY_ADDR(5'd1), .BMCR_VALUE(16'h3300), .STARTUP_CYCLES(10),
    .POLL_CYCLES(50), .ID1_EXPECT(16'h0007), .ID2_EXPECT(12'hC0F)
  ) dut (
    .clk(clk), .rst(rst), .mdio_i(mdio_i), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .busy(busy), .phy_ready(phy_ready), .link_up(link_up),
    .link_change(link_change), .err(err), .phy_id(phy_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    logic        ready;
    logic        link;
    logic        change;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] bmsr_q[$];
  logic [15:0] id1_val;
  int          checks = 0;
  int          errors = 0;
  int          bitn = 0;
  int          rises = 0;
  int          lc_pulses = 0;
  int          busy_cycles = 0;
  logic [63:0] rec_bits = '0;
  logic [63:0] rec_oe = '0;
  logic        prev_mdc = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_lc = 1'b0;
  logic        pend = 1'b0;
  logic        rd_active = 1'b0;
  logic [15:0] rd_data = 16'hFFFF;
  exp_t        cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk_rd(input logic [4:0] ra, input logic [15:0] data,
                                 input logic ready, input logic link, input logic change);
    exp_t e;
    e.bits   = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, ra, 2'b10, data};
    e.oe     = {{46{1'b1}}, {18{1'b0}}};
    e.ready  = ready;
    e.link   = link;
    e.change = change;
    return e;
  endfunction

  function automatic exp_t mk_wr_bmcr();
    exp_t e;
    e.bits   = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h3300};
    e.oe     = {64{1'b1}};
    e.ready  = 1'b1;
    e.link   = 1'b0;
    e.change = 1'b0;
    return e;
  endfunction

  // Monitor plus PHY model, evaluated away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      bitn = 0; phy_oe = 1'b0; phy_o = 1'b1; pend = 1'b0; rd_active = 1'b0;
      prev_mdc = 1'b0; prev_busy = 1'b0; prev_lc = 1'b0; busy_cycles = 0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        check("post_ready", phy_ready, cur.ready);
        check("post_link", link_up, cur.link);
        check("post_change", link_change, cur.change);
      end
      if (link_change) begin
        lc_pulses++;
        check("lc_width", prev_lc, 1'b0);
      end
      if (busy && !prev_busy) begin
        bitn = 0; busy_cycles = 0; rec_bits = '0; rec_oe = '0; rd_active = 1'b0;
      end
      if (busy) busy_cycles++;
      if (mdc && !prev_mdc) begin
        rises++;
        if (bitn < 64) begin
          rec_bits[63-bitn] = mdio_i;
          rec_oe[63-bitn]   = mdio_oe;
        end
        bitn++;
      end
      if (!mdc && prev_mdc) begin
        if (bitn == 46) begin
          rd_active = (rec_bits[29:28] == 2'b10);
          case (rec_bits[22:18])
            5'd2:    rd_data = id1_val;
            5'd3:    rd_data = 16'hC0F1;
            5'd1:    rd_data = (bmsr_q.size() > 0) ? bmsr_q.pop_front() : 16'h7809;
            default: rd_data = 16'hFFFF;
          endcase
        end else if (bitn == 47 && rd_active) begin
          phy_oe = 1'b1; phy_o = 1'b0;
        end else if (bitn >= 48 && bitn <= 63 && rd_active) begin
          phy_o = rd_data[63-bitn];
        end else begin
          phy_oe = 1'b0; phy_o = 1'b1;
        end
      end
      if (!busy && prev_busy) begin
        phy_oe = 1'b0; phy_o = 1'b1;
        check("frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("frame_bits", rec_bits, cur.bits);
          check("frame_oe", rec_oe, cur.oe);
          check("frame_nbits", bitn, 64);
          check("frame_len", busy_cycles, 256);
          pend = 1'b1;
        end
      end
      prev_mdc = mdc; prev_busy = busy; prev_lc = link_change;
    end
  end

  task automatic chk_reset_vals(input string tag);
    check({tag, "_mdc"}, mdc, 1'b0);
    check({tag, "_mdio_o"}, mdio_o, 1'b1);
    check({tag, "_mdio_oe"}, mdio_oe, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ready"}, phy_ready, 1'b0);
    check({tag, "_link"}, link_up, 1'b0);
    check({tag, "_lc"}, link_change, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_phy_id"}, phy_id, 32'd0);
  endtask

  task automatic startup_quiet(input string tag);
    int hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (mdc) hi++;
    end
    check(tag, hi, 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || pend) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, t < budget, 1'b1);
  endtask

  initial begin
    int t;
    int r0;
    id1_val = 16'h0007;
    bmsr_q  = '{16'h7809, 16'h782D, 16'h782D, 16'h7809};
    repeat (3) @(negedge clk);
    chk_reset_vals("init");
    exp_q.push_back(mk_rd(5'd2, 16'h0007, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk_rd(5'd3, 16'hC0F1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk_wr_bmcr());
    exp_q.push_back(mk_rd(5'd1, 16'h7809, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk_rd(5'd1, 16'h782D, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(mk_rd(5'd1, 16'h782D, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk_rd(5'd1, 16'h7809, 1'b1, 1'b0, 1'b1));
    rst = 1'b0;
    startup_quiet("startup_mdc_1");
    drain("seq1_done", 6000);
    check("phy_id_ok", phy_id, 32'h0007C0F1);
    check("err_ok", err, 1'b0);
    check("ready_ok", phy_ready, 1'b1);
    check("lc_count", lc_pulses, 2);

    // Abort the next BMSR read at bit 40.
    t = 0;
    while (!(busy && bitn == 40) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("reach_bit40", t < 1000, 1'b1);
    check("bit40_oe", mdio_oe, 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    repeat (3) @(negedge clk);
    id1_val = 16'h0022;
    exp_q.push_back(mk_rd(5'd2, 16'h0022, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk_rd(5'd3, 16'hC0F1, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    startup_quiet("startup_mdc_2");
    drain("seq2_done", 2000);
    repeat (4) @(negedge clk);
    r0 = rises;
    repeat (10000) @(negedge clk);
    check("fault_no_mdc", rises - r0, 0);
    check("fault_err", err, 1'b1);
    check("fault_ready", phy_ready, 1'b0);
    check("fault_phy_id", phy_id, 32'h0022C0F1);
    check("fault_oe", mdio_oe, 1'b0);
    check("fault_link", link_up, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_mdio_ctrl.md
Name: phy_mdio_ctrl

Overview:
Autonomous MDIO management controller for the LAN8720 RMII PHY. After reset it waits for the PHY to leave its own reset, then reads and checks the PHY ID, writes the BMCR configuration, and polls BMSR periodically. Exports link status that top-level logic uses to gate packet generation. The MDIO pin is tristated at top level from mdio_o/mdio_oe/mdio_i.

Parameters:
CLK_DIV, 14, clk cycles per MDC half-period (27 MHz / 28 ≈ 0.96 MHz MDC)
PHY_ADDR, 5'd1, PHY address placed in every frame
BMCR_VALUE, 16'h3300, value written to reg 0 (100M, AN enable, restart AN, full duplex)
STARTUP_CYCLES, 270000, wait after reset before the first frame (10 ms)
POLL_CYCLES, 2700000, idle gap between BMSR reads (100 ms)
ID1_EXPECT, 16'h0007, required reg 2 value
ID2_EXPECT, 12'hC0F, required reg 3 bits [15:4]

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
mdio_i  in  1  MDIO pin input
mdc  out  1  management clock
mdio_o  out  1  MDIO output data
mdio_oe  out  1  MDIO output enable (1 = drive)
busy  out  1  high while a frame is in progress
phy_ready  out  1  high once the BMCR write has completed; stays high until reset
link_up  out  1  BMSR bit 2 from the most recent poll
link_change  out  1  one-cycle pulse when link_up changes
err  out  1  PHY ID mismatch; sticky until reset
phy_id  out  32  {reg2, reg3} as read

Behaviour:
- Reset, async: mdc=0, mdio_o=1, mdio_oe=0, busy=0, phy_ready=0, link_up=0, link_change=0, err=0, phy_id=0. FSM enters WAIT_START and all counters clear. Reset mid-frame aborts the frame immediately; the full sequence restarts after reset deasserts.
- FSM states: WAIT_START -> RD_ID1 -> RD_ID2 -> CHECK_ID -> WR_BMCR -> POLL_WAIT -> RD_BMSR -> POLL_WAIT ... ; fault path CHECK_ID -> FAULT.
- WAIT_START: count STARTUP_CYCLES, then issue a read of reg 2.
- CHECK_ID (1 cycle): compare reg2 against ID1_EXPECT and reg3[15:4] against ID2_EXPECT.
  - Match -> WR_BMCR.
  - Mismatch -> FAULT: err=1, mdc stays 0, mdio_oe stays 0, no further frames.
- WR_BMCR: write BMCR_VALUE to reg 0. When the frame completes, phy_ready=1.
- POLL_WAIT: count POLL_CYCLES, then issue a read of reg 1.
- After each BMSR read: link_up <= data[2]. link_change pulses for exactly 1 cycle, coincident with the link_up update, only if the value differs. BMSR bit 2 is latch-low, so a drop is reported on the first poll after it occurs.
- Frame format: 64 bits, index 0..63, MSB first.
  - Bits 0-31: preamble, all 1.
  - Bits 32-33: ST = 01.
  - Bits 34-35: OP = 01 for write, 10 for read.
  - Bits 36-40: PHY_ADDR. Bits 41-45: register address.
  - Bits 46-47: TA.
  - Bits 48-63: data.
- Bit timing: each bit is CLK_DIV cycles with mdc=0, then CLK_DIV cycles with mdc=1.
  - mdio_o/mdio_oe update on the cycle mdc falls, or at frame start.
  - mdio_i is sampled on the clk edge where mdc goes 0->1.
- Write frame: mdio_oe=1 for all 64 bits, TA = 10.
- Read frame: mdio_oe=1 for bits 0-45 and 0 for bits 46-63. TA and data bits are not driven. Bits 48-63 are shifted in MSB first.
- Frame end: after the bit 63 high phase, mdc=0, mdio_oe=0, mdio_o=1. busy drops in that same cycle; the next state begins on the following cycle.
- Frame length: 128*CLK_DIV cycles, with busy high throughout. Between frames mdc is idle low.
- phy_id is updated at the end of each ID read: reg2 goes to [31:16], reg3 to [15:0].

Test Plan:
- Reset values: assert rst mid-simulation -> all outputs at reset values the same cycle; mdc=0 for the whole of STARTUP_CYCLES after release.
- ID read (CLK_DIV=2, STARTUP_CYCLES=10, PHY_ADDR=1), PHY model returns 0x0007 / 0xC0F1 -> decoded bits: 32 ones, then 0110, 00001, 00010; mdio_oe falls at bit 46; phy_id=32'h0007C0F1; err=0.
- ID mismatch: PHY model returns 0x0022 for reg 2 -> err=1 after the second read, then no mdc edges for 10000 cycles; phy_ready stays 0.
- BMCR write -> frame bits 0101, 00001, 00000, 10, then 0x3300; mdio_oe=1 for all 64 bits; phy_ready=1 the cycle after busy falls.
- Link polling (POLL_CYCLES=50): BMSR model 0x7809, 0x782D, 0x782D, 0x7809 -> link_up 0,1,1,0; exactly two link_change pulses, each 1 cycle wide.
- Reset during a BMSR read, at bit 40 -> mdio_oe=0 and mdc=0 immediately; after release, link_up=0 and the sequence restarts with WAIT_START and RD_ID1.
